// File: rtl/div_iter.sv
// Iterative 32-bit radix-2 shift-subtract divider with independent operand channels
// and a single-pulse result channel; SIGNED selects two's-complement or unsigned.
module div_iter #(
    parameter bit SIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_axis_divisor_tdata,
    input  logic        s_axis_divisor_tvalid,
    output logic        s_axis_divisor_tready,
    input  logic [31:0] s_axis_dividend_tdata,
    input  logic        s_axis_dividend_tvalid,
    output logic        s_axis_dividend_tready,
    output logic [63:0] m_axis_dout_tdata,
    output logic        m_axis_dout_tvalid
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    dvs_q, dvs_d;
    logic [W-1:0]    dvd_q, dvd_d;
    logic [W-1:0]    dmag_q, dmag_d;
    logic [W-1:0]    rem_q, rem_d;
    logic [W-1:0]    quo_q, quo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  dout_q, dout_d;
    logic            dvs_cap_q, dvs_cap_d;
    logic            dvd_cap_q, dvd_cap_d;
    logic            load_q, load_d;
    logic            dvs_rdy_q, dvs_rdy_d;
    logic            dvd_rdy_q, dvd_rdy_d;
    logic            vld_q, vld_d;

    logic            dvs_hs, dvd_hs;
    logic [W:0]      shifted;
    logic [W+1:0]    diff;
    logic [W-1:0]    rem_nx, quo_nx, q_fix, r_fix;

    // One restoring-division step plus the sign fix-up applied on the final step.
    always_comb begin
        shifted = {rem_q, quo_q[W-1]};
        diff    = {1'b0, shifted} - {2'b00, dmag_q};
        if (!diff[W+1]) begin
            rem_nx = diff[W-1:0];
            quo_nx = {quo_q[W-2:0], 1'b1};
        end else begin
            rem_nx = shifted[W-1:0];
            quo_nx = {quo_q[W-2:0], 1'b0};
        end
        q_fix = (SIGNED && (dvd_q[W-1] ^ dvs_q[W-1])) ? -quo_nx : quo_nx;
        r_fix = (SIGNED && dvd_q[W-1]) ? -rem_nx : rem_nx;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        dvs_d     = dvs_q;
        dvd_d     = dvd_q;
        dmag_d    = dmag_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        dvs_cap_d = dvs_cap_q;
        dvd_cap_d = dvd_cap_q;
        load_d    = load_q;

        dvs_hs = s_axis_divisor_tvalid & dvs_rdy_q;
        dvd_hs = s_axis_dividend_tvalid & dvd_rdy_q;

        case (state_q)
            S_IDLE: begin
                if (dvs_hs) begin
                    dvs_d     = s_axis_divisor_tdata;
                    dvs_cap_d = 1'b1;
                end
                if (dvd_hs) begin
                    dvd_d     = s_axis_dividend_tdata;
                    dvd_cap_d = 1'b1;
                end
                if ((dvs_cap_q | dvs_hs) & (dvd_cap_q | dvd_hs)) begin
                    state_d = S_BUSY;
                    load_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_BUSY: begin
                if (load_q) begin
                    // First busy cycle loads magnitudes from the held operands.
                    load_d = 1'b0;
                    dmag_d = (SIGNED && dvs_q[W-1]) ? -dvs_q : dvs_q;
                    quo_d  = (SIGNED && dvd_q[W-1]) ? -dvd_q : dvd_q;
                    rem_d  = '0;
                end else begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) begin
                        state_d = S_DONE;
                        dout_d  = (dvs_q == '0) ? {{W{1'b1}}, dvd_q} : {q_fix, r_fix};
                    end
                end
            end
            S_DONE: begin
                dvs_cap_d = 1'b0;
                dvd_cap_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        vld_d     = (state_d == S_DONE);
        dvs_rdy_d = (state_d == S_IDLE) & ~dvs_cap_d;
        dvd_rdy_d = (state_d == S_IDLE) & ~dvd_cap_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            dvs_q     <= '0;
            dvd_q     <= '0;
            dmag_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            dout_q    <= '0;
            dvs_cap_q <= 1'b0;
            dvd_cap_q <= 1'b0;
            load_q    <= 1'b0;
            dvs_rdy_q <= 1'b0;
            dvd_rdy_q <= 1'b0;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dvs_q     <= dvs_d;
            dvd_q     <= dvd_d;
            dmag_q    <= dmag_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            dout_q    <= dout_d;
            dvs_cap_q <= dvs_cap_d;
            dvd_cap_q <= dvd_cap_d;
            load_q    <= load_d;
            dvs_rdy_q <= dvs_rdy_d;
            dvd_rdy_q <= dvd_rdy_d;
            vld_q     <= vld_d;
        end
    end

    assign s_axis_divisor_tready  = dvs_rdy_q;
    assign s_axis_dividend_tready = dvd_rdy_q;
    assign m_axis_dout_tdata      = dout_q;
    assign m_axis_dout_tvalid     = vld_q;

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: unsigned and signed instances share stimulus and are
// each compared against a plain-arithmetic division model.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dvs_data, dvd_data;
    logic        dvs_valid, dvd_valid;
    logic        u_dvs_rdy, u_dvd_rdy, u_valid;
    logic        s_dvs_rdy, s_dvd_rdy, s_valid;
    logic [63:0] u_data, s_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    div_iter #(.SIGNED(1'b0)) u_dut (
        .clk                    (clk),
        .reset                  (reset),
        .s_axis_divisor_tdata   (dvs_data),
        .s_axis_divisor_tvalid  (dvs_valid),
        .s_axis_divisor_tready  (u_dvs_rdy),
        .s_axis_dividend_tdata  (dvd_data),
        .s_axis_dividend_tvalid (dvd_valid),
        .s_axis_dividend_tready (u_dvd_rdy),
        .m_axis_dout_tdata      (u_data),
        .m_axis_dout_tvalid     (u_valid)
    );

    div_iter #(.SIGNED(1'b1)) s_dut (
        .clk                    (clk),
        .reset                  (reset),
        .s_axis_divisor_tdata   (dvs_data),
        .s_axis_divisor_tvalid  (dvs_valid),
        .s_axis_divisor_tready  (s_dvs_rdy),
        .s_axis_dividend_tdata  (dvd_data),
        .s_axis_dividend_tvalid (dvd_valid),
        .s_axis_dividend_tready (s_dvd_rdy),
        .m_axis_dout_tdata      (s_data),
        .m_axis_dout_tvalid     (s_valid)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {quotient, remainder}; signed division truncates toward zero.
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (!sgn) begin
            uq = a / b;
            ur = a % b;
            return {uq, ur};
        end
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {q[31:0], r[31:0]};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand pair starting in the current cycle (cycle 0); the second
    // channel arrives at cycle gap. Returns in the first IDLE cycle after the result.
    task automatic run_op(input string tag, input logic [31:0] dvd, input logic [31:0] dvs,
                          input int gap, input bit dvd_first, input bit garbage);
        int          exp_c, cu, cs, nu, ns;
        logic [63:0] du, ds;
        bit          rdy_busy;
        exp_c = gap + 34;
        cu = -1; cs = -1; nu = 0; ns = 0;
        du = '0; ds = '0;
        rdy_busy = 1'b0;
        if (gap == 0) begin
            dvs_valid = 1'b1; dvs_data = dvs;
            dvd_valid = 1'b1; dvd_data = dvd;
        end else if (dvd_first) begin
            dvd_valid = 1'b1; dvd_data = dvd;
        end else begin
            dvs_valid = 1'b1; dvs_data = dvs;
        end
        for (int c = 0; c <= exp_c + 1; c++) begin
            if (c > 0) begin
                step();
                dvs_valid = 1'b0;
                dvd_valid = 1'b0;
                if (garbage) begin
                    dvs_data = $urandom;
                    dvd_data = $urandom;
                end
                if (c == gap) begin
                    if (dvd_first) begin dvs_valid = 1'b1; dvs_data = dvs; end
                    else           begin dvd_valid = 1'b1; dvd_data = dvd; end
                end
            end
            if (c > gap && c <= exp_c)
                rdy_busy |= u_dvs_rdy | u_dvd_rdy | s_dvs_rdy | s_dvd_rdy;
            if (c >= 1 && c <= gap)
                rdy_busy |= dvd_first ? (u_dvd_rdy | s_dvd_rdy) : (u_dvs_rdy | s_dvs_rdy);
            if (u_valid === 1'b1) begin
                nu++;
                if (cu < 0) begin cu = c; du = u_data; end
            end
            if (s_valid === 1'b1) begin
                ns++;
                if (cs < 0) begin cs = c; ds = s_data; end
            end
        end
        check({tag, "_u_lat"},   64'(cu), 64'(exp_c));
        check({tag, "_s_lat"},   64'(cs), 64'(exp_c));
        check({tag, "_u_data"},  du, ref_div(1'b0, dvd, dvs));
        check({tag, "_s_data"},  ds, ref_div(1'b1, dvd, dvs));
        check({tag, "_u_pulse"}, 64'(nu), 64'd1);
        check({tag, "_s_pulse"}, 64'(ns), 64'd1);
        check({tag, "_busy_rdy"}, 64'(rdy_busy), 64'd0);
        check({tag, "_idle_rdy"}, 64'({u_dvs_rdy, u_dvd_rdy, s_dvs_rdy, s_dvd_rdy}), 64'hF);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int npulse;
        bit rdy_lost;
        reset = 1'b1;
        dvs_valid = 1'b0; dvd_valid = 1'b0;
        dvs_data = '0; dvd_data = '0;
        #3;
        check("rst_u_data",  u_data, 64'd0);
        check("rst_s_data",  s_data, 64'd0);
        check("rst_valid",   64'({u_valid, s_valid}), 64'd0);
        step(); step();
        #3 reset = 1'b0;
        step();
        check("rst_rdy", 64'({u_dvs_rdy, u_dvd_rdy, s_dvs_rdy, s_dvd_rdy}), 64'hF);

        run_op("u100_7",   32'd100,         32'd7,           0, 1'b0, 1'b0);
        run_op("neg7_2",   32'hFFFF_FFF9,   32'd2,           0, 1'b0, 1'b0);
        run_op("7_neg2",   32'd7,           32'hFFFF_FFFE,   0, 1'b0, 1'b0);
        run_op("ovf",      32'h8000_0000,   32'hFFFF_FFFF,   0, 1'b0, 1'b0);
        run_op("div0",     32'h1234_5678,   32'd0,           0, 1'b0, 1'b0);
        run_op("div0neg",  32'h8765_4321,   32'd0,           0, 1'b0, 1'b0);
        run_op("gap3",     32'd50,          32'd9,           3, 1'b0, 1'b1);
        run_op("dvdfirst", 32'hFFFF_FF9C,   32'd5,           5, 1'b1, 1'b1);

        // Abandon an operation mid-iteration with an asynchronous reset.
        dvs_valid = 1'b1; dvs_data = 32'd7;
        dvd_valid = 1'b1; dvd_data = 32'd1000;
        step();
        dvs_valid = 1'b0; dvd_valid = 1'b0;
        for (int c = 1; c < 12; c++) step();
        #3 reset = 1'b1;
        #1;
        check("midrst_valid",  64'({u_valid, s_valid}), 64'd0);
        check("midrst_u_data", u_data, 64'd0);
        check("midrst_s_data", s_data, 64'd0);
        step(); step();
        #3 reset = 1'b0;
        npulse = 0;
        rdy_lost = 1'b0;
        for (int c = 0; c < 50; c++) begin
            step();
            if (u_valid !== 1'b0 || s_valid !== 1'b0) npulse++;
            if ({u_dvs_rdy, u_dvd_rdy, s_dvs_rdy, s_dvd_rdy} !== 4'hF) rdy_lost = 1'b1;
        end
        check("midrst_nopulse", 64'(npulse), 64'd0);
        check("midrst_rdy",     64'(rdy_lost), 64'd0);
        run_op("after_rst", 32'd20, 32'd3, 0, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++)
            run_op($sformatf("rnd%0d", i), pick(), pick(), 0, 1'b0, 1'($urandom_range(0, 1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Iterative 32-bit radix-2 shift-subtract divider. It is the responder side of the operand/result stream handshake that exe_stage drives for DIV/MOD instructions.
- It replaces the vendor divider cores with in-house RTL. The port set is pin-compatible: two input channels (divisor, dividend) with valid/ready, and one result channel with valid only.
- Two instances are used, SIGNED=1 and SIGNED=0, matching the existing signed and unsigned divider slots.

Parameters:
- SIGNED, 1, 1: two's-complement operands and results. 0: unsigned.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- s_axis_divisor_tdata  input  32  divisor
- s_axis_divisor_tvalid  input  1  divisor valid
- s_axis_divisor_tready  output  1  divisor slot can accept
- s_axis_dividend_tdata  input  32  dividend
- s_axis_dividend_tvalid  input  1  dividend valid
- s_axis_dividend_tready  output  1  dividend slot can accept
- m_axis_dout_tdata  output  64  {quotient[63:32], remainder[31:0]}
- m_axis_dout_tvalid  output  1  result valid, one-cycle pulse

Behaviour:
- Reset (async, asserts immediately):
  - state=IDLE; both operand-captured flags=0; iteration counter=0.
  - m_axis_dout_tvalid=0; m_axis_dout_tdata=0.
  - Both treadys=1 from the first edge after reset deasserts.
- Channel handshake:
  - A channel transfers on a rising edge where tvalid&tready=1.
  - s_axis_X_tready = (state==IDLE) & !X_captured.
  - Channels are independent. Operands may arrive in the same cycle or in either order, any cycles apart.
  - A captured operand is held in its own register; the channel's tready is then 0 until the result is delivered.
  - tready never depends on tvalid, so there is no combinational valid-to-ready path.
- States:
  - IDLE -> BUSY on the edge at which the second operand is captured. If both are captured together, that same edge.
  - BUSY: 32 iterations, counter 0..31, one per cycle. Counter==31 -> DONE.
  - DONE: m_axis_dout_tvalid=1 for exactly this cycle. Captured flags clear. -> IDLE.
  - Result latency: last operand handshake at edge E; tvalid is high in the cycle following edge E+33.
  - A new operand may be accepted in the first IDLE cycle after DONE, so back-to-back throughput is one result per 34 cycles.
- Arithmetic:
  - On BUSY entry, load |dividend| and |divisor| when SIGNED=1, raw values when SIGNED=0.
  - Each iteration: shift the 64-bit partial remainder left by 1; trial-subtract the divisor magnitude from the upper 33 bits; on non-negative, commit and shift quotient bit 1, else shift 0.
  - Sign fix-up is applied when the result register is loaded:
    - quotient negated if sign(dividend)^sign(divisor);
    - remainder negated if sign(dividend). Quotient truncates toward zero.
  - Overflow, SIGNED, 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0. This falls out naturally; no special case is needed.
  - Divide by zero (divisor==0), either mode: quotient=0xFFFFFFFF, remainder=dividend (raw input bits). Latency is still the full 34 cycles.
- Output data:
  - m_axis_dout_tdata is registered.
  - It updates only at the edge entering DONE and holds until the next DONE or reset.
  - The consumer samples tdata while tvalid is high. There is no backpressure on the result channel.
- Input data:
  - tdata changes on a channel while it is not ready are ignored.
  - Captured operands are not re-read after capture.
- Reset mid-operation: the operation is abandoned and no tvalid pulse is produced.
- No X on any output after reset.

Test Plan:
- SIGNED=0: dividend=100, divisor=7, both valid in cycle 0 -> tvalid in cycle 34 exactly, tdata={0x0000000E,0x00000002}; both treadys 0 in cycles 1..34, 1 in cycle 35.
- SIGNED=1: dividend=-7 (0xFFFFFFF9), divisor=2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also dividend=7, divisor=-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- SIGNED=1: 0x80000000 / 0xFFFFFFFF -> {0x80000000,0x00000000}. Either mode, 0x12345678 / 0 -> {0xFFFFFFFF,0x12345678}, latency 34.
- Divisor=9 valid in cycle 0, dividend=50 valid in cycle 3:
  - divisor_tready drops after cycle 0;
  - dividend tdata garbage driven in cycles 1-2 without tvalid is ignored;
  - tvalid in cycle 37 with {5,5}.
- Reset asserted mid-cycle during BUSY iteration 10, released 2 cycles later -> tvalid/tdata 0 immediately; no pulse ever appears; treadys=1; a following 20/3 yields {6,2}.
- Random back-to-back stream: 1000 operand pairs per mode, with tvalid asserted every IDLE cycle -> one result per 34 cycles, all matching the reference model, including INT_MIN, 0, and ±1 corners.
